// File: rtl/vga_bank_pkg.sv
// Shared constants for the VGA display register bank.
// Used by both the bank writer and the pointer-stage reader.
package vga_bank_pkg;

  localparam int NUM_REGS = 13;
  localparam int DATA_W   = 8;

  localparam logic [3:0] ADDR_SEG_RELOJ  = 4'd1;
  localparam logic [3:0] ADDR_MIN_RELOJ  = 4'd2;
  localparam logic [3:0] ADDR_HOR_RELOJ  = 4'd3;
  localparam logic [3:0] ADDR_DAY        = 4'd4;
  localparam logic [3:0] ADDR_MONTH      = 4'd5;
  localparam logic [3:0] ADDR_YEAR       = 4'd6;
  localparam logic [3:0] ADDR_SEG_CRONO  = 4'd7;
  localparam logic [3:0] ADDR_MIN_CRONO  = 4'd8;
  localparam logic [3:0] ADDR_HOR_CRONO  = 4'd9;
  localparam logic [3:0] ADDR_RING_CRONO = 4'd10;
  localparam logic [3:0] ADDR_ACT_CRONO  = 4'd11;
  localparam logic [3:0] ADDR_CURSOR     = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic is_time_addr(
    input logic [3:0] a
  );
    return (a >= ADDR_SEG_RELOJ) &&
           (a <= ADDR_HOR_CRONO);
  endfunction

  function automatic logic is_flag_addr(
    input logic [3:0] a
  );
    return (a == ADDR_RING_CRONO) ||
           (a == ADDR_ACT_CRONO);
  endfunction

endpackage

// File: rtl/vga_reg_bank_writer_if.sv
// Write port of the display register bank.
// Valid/ready handshake from the RTC/chrono control logic.
interface vga_reg_bank_writer_if;
  import vga_bank_pkg::*;

  logic              WrValid;
  logic              WrReady;
  logic [3:0]        WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              WrIsBCD;

  modport master (
    output WrValid,
    output WrAddr,
    output WrData,
    output WrIsBCD,
    input  WrReady
  );

  modport slave (
    input  WrValid,
    input  WrAddr,
    input  WrData,
    input  WrIsBCD,
    output WrReady
  );

endinterface

// File: rtl/bcd2bin.sv
// Packed two-digit BCD to 7-bit binary.
// Flags any nibble above 9 as invalid.
module bcd2bin (
  input  logic [7:0] i_bcd,
  output logic [6:0] o_bin,
  output logic       o_invalid
);

  logic [6:0] w_tens;
  logic [6:0] w_units;

  assign w_tens  = {3'b000, i_bcd[7:4]};
  assign w_units = {3'b000, i_bcd[3:0]};

  // tens*10 as tens*8 + tens*2
  assign o_bin = (w_tens << 3) +
                 (w_tens << 1) +
                 w_units;

  assign o_invalid = (i_bcd[7:4] > 4'd9) ||
                     (i_bcd[3:0] > 4'd9);

endmodule

// File: rtl/vga_reg_bank_writer.sv
// Shadow/display register bank for the VGA time overlay.
// Writes land in shadow; FrameSync copies them to display.
module vga_reg_bank_writer
  import vga_bank_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  vga_reg_bank_writer_if.slave wr,
  input  logic              FrameSync,
  input  logic [3:0]        MemAddrIN,
  output logic [DATA_W-1:0] MemDataOUT,
  output logic              CommitDone,
  output logic              BcdError,
  output logic              AddrError
);

  state_t r_state;
  state_t w_next_state;

  logic [DATA_W-1:0] r_shadow  [NUM_REGS];
  logic [DATA_W-1:0] r_display [NUM_REGS];

  logic [3:0] r_idx;
  logic       r_dirty;
  logic       r_commit_done;
  logic       r_bcd_err;
  logic       r_addr_err;

  logic              w_idle;
  logic              w_ready;
  logic              w_accept;
  logic              w_is_time;
  logic              w_is_flag;
  logic              w_is_cursor;
  logic [6:0]        w_bin;
  logic              w_bcd_inv;
  logic              w_store;
  logic [DATA_W-1:0] w_store_data;
  logic              w_bcd_bad;
  logic              w_addr_bad;
  logic              w_commit_go;

  bcd2bin u_bcd2bin (
    .i_bcd     (wr.WrData),
    .o_bin     (w_bin),
    .o_invalid (w_bcd_inv)
  );

  assign w_idle     = (r_state == ST_IDLE);
  assign w_ready    = w_idle & RESET;
  assign wr.WrReady = w_ready;
  assign w_accept   = wr.WrValid & w_ready;

  assign w_is_time   = is_time_addr(wr.WrAddr);
  assign w_is_flag   = is_flag_addr(wr.WrAddr);
  assign w_is_cursor = (wr.WrAddr == ADDR_CURSOR);

  // A write in the FrameSync cycle also counts as pending
  assign w_commit_go = w_idle & FrameSync &
                       (r_dirty | w_store);

  // Decode an accepted write into store data or an error
  always_comb begin
    w_store      = 1'b0;
    w_store_data = '0;
    w_bcd_bad    = 1'b0;
    w_addr_bad   = 1'b0;
    if (w_accept) begin
      unique case (1'b1)
        w_is_time: begin
          if (wr.WrIsBCD && w_bcd_inv) begin
            w_bcd_bad = 1'b1;
          end else begin
            w_store      = 1'b1;
            w_store_data = wr.WrIsBCD ?
              {1'b0, w_bin} :
              {1'b0, wr.WrData[6:0]};
          end
        end
        w_is_flag: begin
          w_store      = 1'b1;
          w_store_data = {7'b0, wr.WrData[0]};
        end
        w_is_cursor: begin
          w_store      = 1'b1;
          w_store_data = wr.WrData;
        end
        default: w_addr_bad = 1'b1;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_commit_go) w_next_state = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (r_idx == ADDR_CURSOR) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Banks, copy index, dirty and sticky flags
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i]  <= '0;
        r_display[i] <= '0;
      end
      r_idx         <= '0;
      r_dirty       <= 1'b0;
      r_commit_done <= 1'b0;
      r_bcd_err     <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      if (w_store) r_shadow[wr.WrAddr] <= w_store_data;
      if (w_bcd_bad)  r_bcd_err  <= 1'b1;
      if (w_addr_bad) r_addr_err <= 1'b1;
      if (w_commit_go) begin
        r_dirty <= 1'b0;
        r_idx   <= ADDR_SEG_RELOJ;
      end else if (w_store) begin
        r_dirty <= 1'b1;
      end
      if (r_state == ST_COMMIT) begin
        r_display[r_idx] <= r_shadow[r_idx];
        r_idx            <= r_idx + 4'd1;
      end
      r_commit_done <= (r_state == ST_DONE);
    end
  end

  assign MemDataOUT =
    ((MemAddrIN != 4'd0) && (MemAddrIN <= ADDR_CURSOR)) ?
    r_display[MemAddrIN] : '0;

  assign CommitDone = r_commit_done;
  assign BcdError   = r_bcd_err;
  assign AddrError  = r_addr_err;

endmodule

// File: tb/tb_vga_reg_bank_writer.sv
// Directed bench for vga_reg_bank_writer.
// Each task drives one scenario and checks inline.
module tb_vga_reg_bank_writer;
  import vga_bank_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       fs    = 1'b0;
  logic [3:0] raddr = 4'd0;
  logic [7:0] rdata;
  logic       cdone;
  logic       berr;
  logic       aerr;

  int errors = 0;
  int checks = 0;

  vga_reg_bank_writer_if bus();

  vga_reg_bank_writer dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .wr         (bus.slave),
    .FrameSync  (fs),
    .MemAddrIN  (raddr),
    .MemDataOUT (rdata),
    .CommitDone (cdone),
    .BcdError   (berr),
    .AddrError  (aerr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(
    input logic [3:0] a,
    input logic [7:0] d,
    input logic       b
  );
    int n;
    n = 0;
    bus.WrValid = 1'b1;
    bus.WrAddr  = a;
    bus.WrData  = d;
    bus.WrIsBCD = b;
    while (bus.WrReady !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL write_timeout addr=%0d got ready=%b exp 1",
               a, bus.WrReady);
    end
    step();
    bus.WrValid = 1'b0;
  endtask

  task automatic run_frame(output int cnt);
    cnt = 0;
    fs  = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) fs = 1'b0;
      if (cdone === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset();
    bus.WrValid = 1'b0;
    bus.WrAddr  = 4'd0;
    bus.WrData  = 8'd0;
    bus.WrIsBCD = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (bus.WrReady !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready_in_reset got=%b exp=0", bus.WrReady);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.WrReady !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got=%b exp=1", bus.WrReady);
    end
    checks++;
    if ({cdone, berr, aerr} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags got=%b exp=000", {cdone, berr, aerr});
    end
    for (int a = 0; a < 16; a++) begin
      raddr = a[3:0];
      #1;
      checks++;
      if (rdata !== 8'h00) begin
        errors++;
        $display("FAIL rst_read addr=%0d got=%0h exp=0", a, rdata);
      end
    end
  endtask

  task automatic test_bcd_commit();
    int done_at;
    int done_cnt;
    do_write(ADDR_HOR_RELOJ, 8'h23, 1'b1);
    raddr = ADDR_HOR_RELOJ;
    #1;
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL bcd_pre_commit got=%0h exp=0", rdata);
    end
    done_at  = 0;
    done_cnt = 0;
    fs = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) fs = 1'b0;
      if (cdone === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 3) begin
        checks++;
        if (rdata !== 8'h00) begin
          errors++;
          $display("FAIL bcd_before_copy got=%0h exp=0", rdata);
        end
      end
      if (k == 4) begin
        checks++;
        if (rdata !== 8'd23) begin
          errors++;
          $display("FAIL bcd_after_copy got=%0d exp=23", rdata);
        end
      end
      if (k == 13) begin
        checks++;
        if (bus.WrReady !== 1'b0) begin
          errors++;
          $display("FAIL bcd_ready_done got=%b exp=0", bus.WrReady);
        end
      end
      if (k == 14) begin
        checks++;
        if (bus.WrReady !== 1'b1) begin
          errors++;
          $display("FAIL bcd_ready_idle got=%b exp=1", bus.WrReady);
        end
      end
    end
    checks++;
    if (done_cnt !== 1 || done_at !== 14) begin
      errors++;
      $display("FAIL bcd_commit_done got cnt=%0d at=%0d exp cnt=1 at=14",
               done_cnt, done_at);
    end
  endtask

  task automatic test_data_rules();
    logic [7:0] exp_v [13];
    int cnt;
    exp_v = '{8'h00, 8'h41, 8'h00, 8'h07, 8'h63, 8'h00, 8'h7F,
              8'h0A, 8'h09, 8'h3B, 8'h01, 8'h00, 8'hAF};
    do_write(4'd1,  8'hC1, 1'b0);
    do_write(4'd2,  8'h00, 1'b1);
    do_write(4'd3,  8'h07, 1'b0);
    do_write(4'd4,  8'h99, 1'b1);
    do_write(4'd5,  8'h80, 1'b0);
    do_write(4'd6,  8'h7F, 1'b0);
    do_write(4'd7,  8'h10, 1'b1);
    do_write(4'd8,  8'h09, 1'b1);
    do_write(4'd9,  8'h11, 1'b0);
    do_write(4'd9,  8'h59, 1'b1);
    do_write(4'd10, 8'hFF, 1'b1);
    do_write(4'd11, 8'hFE, 1'b0);
    do_write(4'd12, 8'hAF, 1'b1);
    run_frame(cnt);
    checks++;
    if (cnt !== 1) begin
      errors++;
      $display("FAIL rules_commit_cnt got=%0d exp=1", cnt);
    end
    checks++;
    if ({berr, aerr} !== 2'b00) begin
      errors++;
      $display("FAIL rules_flags got=%b exp=00", {berr, aerr});
    end
    for (int a = 1; a <= 12; a++) begin
      raddr = a[3:0];
      #1;
      checks++;
      if (rdata !== exp_v[a]) begin
        errors++;
        $display("FAIL rules_read addr=%0d got=%0h exp=%0h",
                 a, rdata, exp_v[a]);
      end
    end
  endtask

  task automatic test_errors();
    int cnt;
    do_write(ADDR_MONTH, 8'h1A, 1'b1);
    checks++;
    if ({berr, aerr} !== 2'b10) begin
      errors++;
      $display("FAIL err_bcd_flags got=%b exp=10", {berr, aerr});
    end
    run_frame(cnt);
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL err_bcd_no_commit got=%0d exp=0", cnt);
    end
    raddr = ADDR_MONTH;
    #1;
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL err_bcd_read got=%0h exp=0", rdata);
    end
    do_write(4'd14, 8'h55, 1'b0);
    checks++;
    if ({berr, aerr} !== 2'b11) begin
      errors++;
      $display("FAIL err_addr_flags got=%b exp=11", {berr, aerr});
    end
    checks++;
    if (bus.WrReady !== 1'b1) begin
      errors++;
      $display("FAIL err_addr_ready got=%b exp=1", bus.WrReady);
    end
    run_frame(cnt);
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL err_addr_no_commit got=%0d exp=0", cnt);
    end
    raddr = 4'd14;
    #1;
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL err_read14 got=%0h exp=0", rdata);
    end
    raddr = ADDR_HOR_RELOJ;
    #1;
    checks++;
    if (rdata !== 8'h07) begin
      errors++;
      $display("FAIL err_read3 got=%0h exp=7", rdata);
    end
  endtask

  task automatic test_back_to_back();
    int low;
    int first_ready;
    int done_at;
    int cnt;
    low         = 0;
    first_ready = 0;
    done_at     = 0;
    bus.WrValid = 1'b1;
    bus.WrAddr  = ADDR_SEG_RELOJ;
    bus.WrData  = 8'h45;
    bus.WrIsBCD = 1'b1;
    fs = 1'b1;
    checks++;
    if (bus.WrReady !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_start got=%b exp=1", bus.WrReady);
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        fs          = 1'b0;
        bus.WrAddr  = ADDR_MIN_RELOJ;
        bus.WrData  = 8'h37;
      end
      if (first_ready != 0 && k == first_ready + 1)
        bus.WrValid = 1'b0;
      if (first_ready == 0) begin
        if (bus.WrReady === 1'b0) low++;
        else first_ready = k;
      end
      if (cdone === 1'b1) done_at = k;
    end
    bus.WrValid = 1'b0;
    checks++;
    if (low !== 13 || first_ready !== 14) begin
      errors++;
      $display("FAIL b2b_backpressure got low=%0d ready_at=%0d exp 13/14",
               low, first_ready);
    end
    checks++;
    if (done_at !== 14) begin
      errors++;
      $display("FAIL b2b_commit_done got=%0d exp=14", done_at);
    end
    raddr = ADDR_SEG_RELOJ;
    #1;
    checks++;
    if (rdata !== 8'd45) begin
      errors++;
      $display("FAIL b2b_sync_write got=%0d exp=45", rdata);
    end
    raddr = ADDR_MIN_RELOJ;
    #1;
    checks++;
    if (rdata !== 8'd0) begin
      errors++;
      $display("FAIL b2b_held_pending got=%0d exp=0", rdata);
    end
    run_frame(cnt);
    raddr = ADDR_MIN_RELOJ;
    #1;
    checks++;
    if (cnt !== 1 || rdata !== 8'd37) begin
      errors++;
      $display("FAIL b2b_held_commit got cnt=%0d val=%0d exp 1/37",
               cnt, rdata);
    end
  endtask

  task automatic test_reset_mid_commit();
    int cnt;
    for (int a = 1; a <= 12; a++)
      do_write(a[3:0], 8'h20 + a[7:0], 1'b0);
    raddr = ADDR_SEG_RELOJ;
    fs = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) fs = 1'b0;
    end
    checks++;
    if (rdata !== 8'h21 || cdone !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre_reset got val=%0h done=%b exp 21/0",
               rdata, cdone);
    end
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (bus.WrReady !== 1'b0) begin
      errors++;
      $display("FAIL mid_ready_in_reset got=%b exp=0", bus.WrReady);
    end
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (cdone === 1'b1) cnt++;
    end
    checks++;
    if (cnt !== 0 || bus.WrReady !== 1'b1) begin
      errors++;
      $display("FAIL mid_after got done=%0d ready=%b exp 0/1",
               cnt, bus.WrReady);
    end
    checks++;
    if ({berr, aerr} !== 2'b00) begin
      errors++;
      $display("FAIL mid_flags got=%b exp=00", {berr, aerr});
    end
    for (int a = 0; a < 16; a++) begin
      raddr = a[3:0];
      #1;
      checks++;
      if (rdata !== 8'h00) begin
        errors++;
        $display("FAIL mid_read addr=%0d got=%0h exp=0", a, rdata);
      end
    end
  endtask

  task automatic test_idle_sync();
    int cnt;
    int rlow;
    cnt  = 0;
    rlow = 0;
    fs = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) fs = 1'b0;
      if (cdone === 1'b1) cnt++;
      if (bus.WrReady !== 1'b1) rlow++;
    end
    checks++;
    if (cnt !== 0 || rlow !== 0) begin
      errors++;
      $display("FAIL idle_sync got done=%0d ready_low=%0d exp 0/0",
               cnt, rlow);
    end
    raddr = ADDR_CURSOR;
    #1;
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL idle_read got=%0h exp=0", rdata);
    end
  endtask

  initial begin
    test_reset();
    test_bcd_commit();
    test_data_rules();
    test_errors();
    test_back_to_back();
    test_reset_mid_commit();
    test_idle_sync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
